// File: rtl/keypad_scanner_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
// The master presents the head-of-queue key code with key_valid; the slave
// pops it by holding key_ready high in the same cycle.
interface keypad_scanner_if #(
  parameter int KW = 4
) ();

  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes active-low columns, samples active-low rows
// through a two-flop synchroniser, debounces press and release, and queues one
// key code per physical press into a small first-word-fall-through FIFO.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | all columns strobed, waiting for any row to go low
// ST_SCAN       | one column strobed at a time, settle then sample rows
// ST_DEBOUNCE   | candidate key found, row must stay low for the window
// ST_PRESSED    | key confirmed and queued, waiting for all rows high
// ST_RELEASE_DB | rows high, must stay high for the window before idling
module keypad_scanner #(
  parameter  int ROWS            = 4,
  parameter  int COLS            = 4,
  parameter  int DEBOUNCE_CYCLES = 2_000_000,
  parameter  int SETTLE_CYCLES   = 4,
  parameter  int FIFO_DEPTH      = 4,
  localparam int KW              = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  keypad_scanner_if.master evt,
  output logic            key_held,
  output logic [KW-1:0]   held_code,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SET_TC   = SW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SCAN       = 3'd1;
  localparam logic [2:0] ST_DEBOUNCE   = 3'd2;
  localparam logic [2:0] ST_PRESSED    = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;

  logic [ROWS-1:0] rs_meta;
  logic [ROWS-1:0] rs;
  logic            rs_all_ones;
  logic [RW-1:0]   low_row;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   col_nxt;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   row_nxt;
  logic [SW-1:0]   set_cnt;
  logic [SW-1:0]   set_nxt;
  logic [DW-1:0]   db_cnt;
  logic [DW-1:0]   db_nxt;
  logic [DW-1:0]   db_inc;
  logic            push;
  logic [KW-1:0]   cur_code;

  logic [KW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            fifo_valid;
  logic            pop;
  logic            do_push;
  logic            drop;

  // Two-flop synchroniser for the asynchronous row returns; idles high (no key).
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta <= '1;
      rs      <= '1;
    end else begin
      rs_meta <= row_in;
      rs      <= rs_meta;
    end
  end

  assign rs_all_ones = &rs;
  assign db_inc      = db_cnt + 1'b1;
  assign cur_code    = KW'(row_q) * KW'(COLS) + KW'(col_q);

  // Priority pick of the lowest-index row currently pulled low.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) begin
        low_row = RW'(i);
      end
    end
  end

  // Next-state, column/row selection and counter updates for the scan FSM.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_q;
    row_nxt   = row_q;
    set_nxt   = set_cnt;
    db_nxt    = db_cnt;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rs_all_ones) begin
          state_nxt = ST_SCAN;
          col_nxt   = '0;
          set_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (set_cnt != SET_TC) begin
          set_nxt = set_cnt + 1'b1;
        end else if (!rs_all_ones) begin
          state_nxt = ST_DEBOUNCE;
          row_nxt   = low_row;
          db_nxt    = '0;
        end else if (col_q == COL_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          col_nxt = col_q + 1'b1;
          set_nxt = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!rs[row_q]) begin
          db_nxt = db_inc;
          if (db_inc == DB_TC) begin
            state_nxt = ST_PRESSED;
            push      = 1'b1;
          end
        end else begin
          // Row bounced back before the window elapsed: treat as noise.
          state_nxt = ST_IDLE;
          db_nxt    = '0;
        end
      end
      ST_PRESSED: begin
        if (rs_all_ones) begin
          state_nxt = ST_RELEASE_DB;
          db_nxt    = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (rs_all_ones) begin
          db_nxt = db_inc;
          if (db_inc == DB_TC) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          // Release bounce: key is still held, no new event.
          state_nxt = ST_PRESSED;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
        set_nxt   = '0;
        db_nxt    = '0;
      end
    endcase
  end

  // FSM registers plus registered column strobes and held-key status so the
  // keypad pins never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      set_cnt   <= '0;
      db_cnt    <= '0;
      col_out   <= '0;
      key_held  <= 1'b0;
      held_code <= '0;
    end else begin
      state    <= state_nxt;
      col_q    <= col_nxt;
      row_q    <= row_nxt;
      set_cnt  <= set_nxt;
      db_cnt   <= db_nxt;
      col_out  <= (state_nxt == ST_IDLE) ? '0 : ~(COLS'(1) << col_nxt);
      key_held <= (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_DB);
      if (push) begin
        held_code <= cur_code;
      end
    end
  end

  assign full       = (count == DEPTH_C);
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid & evt.key_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push    = push & (~full | pop);
  assign drop       = push & full & ~pop;

  assign evt.key_valid = fifo_valid;
  assign evt.key_code  = fifo_valid ? mem[rd_ptr] : '0;

  // Event FIFO storage and pointers; depth is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= cur_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DB    = 8;
  localparam int ST    = 3;
  localparam int DEPTH = 4;
  localparam int KW    = 4;

  logic            clk;
  logic            rst;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic            key_held;
  logic [KW-1:0]   held_code;
  logic            overflow;
  logic            overflow_clr;

  logic [ROWS*COLS-1:0] key_down;
  logic [ROWS-1:0]      row_force;

  int checks;
  int errors;

  keypad_scanner_if #(.KW(KW)) evt ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DB),
    .SETTLE_CYCLES(ST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .evt(evt),
    .key_held(key_held),
    .held_code(held_code),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a down key shorts its row to a strobed (low) column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (key_down[r*COLS+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
      end
      if (row_force[r]) row_in[r] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press a key until it is held, release it until idle; ok reports both seen.
  task automatic do_press(input int code, output bit ok, output logic [KW-1:0] hc);
    bit seen;
    seen = 1'b0;
    key_down[code] = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (key_held === 1'b1) seen = 1'b1;
    end
    ok = seen;
    hc = held_code;
    key_down[code] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (key_held === 1'b0) seen = 1'b1;
    end
    ok = ok & seen;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL reset_col_out got=%b exp=0000", col_out); end
    checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b exp=0", evt.key_valid); end
    checks++; if (evt.key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code got=%0d exp=0", evt.key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held got=%b exp=0", key_held); end
    checks++; if (held_code !== 4'd0) begin errors++; $display("FAIL reset_held_code got=%0d exp=0", held_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_press();
    int first_valid, valid_cycles, first_held, last_held;
    logic [KW-1:0] code_seen;
    first_valid = -1; valid_cycles = 0; first_held = -1; last_held = -1;
    code_seen = '0;
    evt.key_ready = 1'b1;
    key_down[9] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (evt.key_valid === 1'b1) begin
        valid_cycles++;
        if (first_valid < 0) begin
          first_valid = i;
          code_seen = evt.key_code;
        end
      end
      if (key_held === 1'b1 && first_held < 0) first_held = i;
    end
    key_down[9] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (key_held === 1'b1) last_held = i;
    end
    checks++; if (first_valid != 19) begin errors++; $display("FAIL press_latency got=%0d exp=19", first_valid); end
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL press_valid_cycles got=%0d exp=1", valid_cycles); end
    checks++; if (code_seen !== 4'd9) begin errors++; $display("FAIL press_key_code got=%0d exp=9", code_seen); end
    checks++; if (first_held != 19) begin errors++; $display("FAIL press_held_rise got=%0d exp=19", first_held); end
    checks++; if (held_code !== 4'd9) begin errors++; $display("FAIL press_held_code got=%0d exp=9", held_code); end
    checks++; if (last_held != 10) begin errors++; $display("FAIL release_held_fall got=%0d exp=10", last_held); end
    checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL press_idle_col_out got=%b exp=0000", col_out); end
    evt.key_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_row_bounce();
    int bad;
    logic [COLS-1:0] col_t7, col_t8;
    bad = 0; col_t7 = '0; col_t8 = '0;
    evt.key_ready = 1'b1;
    row_force[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) row_force[0] = 1'b0;
      if (i == 7) col_t7 = col_out;
      if (i == 8) col_t8 = col_out;
      if (evt.key_valid !== 1'b0 || key_held !== 1'b0) bad++;
    end
    checks++; if (col_t7 !== 4'b1110) begin errors++; $display("FAIL bounce_debounce_col got=%b exp=1110", col_t7); end
    checks++; if (col_t8 !== 4'b0000) begin errors++; $display("FAIL bounce_back_to_idle got=%b exp=0000", col_t8); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_no_event got=%0d exp=0", bad); end
    checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL bounce_final_col got=%b exp=0000", col_out); end
    evt.key_ready = 1'b0;
  endtask

  task automatic test_release_bounce();
    int events, held_low;
    bit seen;
    logic held_t17;
    events = 0; held_low = 0; seen = 1'b0; held_t17 = 1'b1;
    evt.key_ready = 1'b1;
    key_down[0] = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (evt.key_valid === 1'b1) events++;
      if (key_held === 1'b1) seen = 1'b1;
    end
    repeat (5) begin
      tick();
      if (evt.key_valid === 1'b1) events++;
    end
    key_down[0] = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 4) key_down[0] = 1'b1;
      if (i == 6) key_down[0] = 1'b0;
      if (evt.key_valid === 1'b1) events++;
      if (i <= 16 && key_held !== 1'b1) held_low++;
      if (i == 17) held_t17 = key_held;
    end
    checks++; if (!seen) begin errors++; $display("FAIL relb_press_held got=0 exp=1"); end
    checks++; if (held_low != 0) begin errors++; $display("FAIL relb_held_during_bounce got=%0d low cycles exp=0", held_low); end
    checks++; if (held_t17 !== 1'b0) begin errors++; $display("FAIL relb_held_fall got=%b exp=0", held_t17); end
    checks++; if (events != 1) begin errors++; $display("FAIL relb_event_count got=%0d exp=1", events); end
    checks++; if (held_code !== 4'd0) begin errors++; $display("FAIL relb_held_code got=%0d exp=0", held_code); end
    evt.key_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int codes [5];
    bit ok;
    logic [KW-1:0] hc;
    codes = '{5, 10, 3, 12, 15};
    evt.key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_press(codes[k], ok, hc);
      checks++; if (!ok || hc !== KW'(codes[k])) begin errors++; $display("FAIL ovf_press_%0d got=%0d ok=%0d exp=%0d", k, hc, ok, codes[k]); end
      if (k == 3) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (evt.key_valid !== 1'b1 || evt.key_code !== KW'(codes[k])) begin
        errors++; $display("FAIL ovf_drain_%0d got=%0d valid=%b exp=%0d", k, evt.key_code, evt.key_valid, codes[k]);
      end
      evt.key_ready = 1'b1;
      tick();
      evt.key_ready = 1'b0;
    end
    checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", evt.key_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    int exp_codes [4];
    bit ok, seen;
    logic [KW-1:0] hc;
    logic held_t14;
    exp_codes = '{2, 3, 4, 8};
    evt.key_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      do_press(k, ok, hc);
      checks++; if (!ok || hc !== KW'(k)) begin errors++; $display("FAIL b2b_fill_%0d got=%0d ok=%0d exp=%0d", k, hc, ok, k); end
    end
    checks++; if (evt.key_code !== 4'd1) begin errors++; $display("FAIL b2b_head got=%0d exp=1", evt.key_code); end
    key_down[8] = 1'b1;
    repeat (14) tick();
    held_t14 = key_held;
    evt.key_ready = 1'b1;
    tick();
    evt.key_ready = 1'b0;
    checks++; if (held_t14 !== 1'b0 || key_held !== 1'b1) begin errors++; $display("FAIL b2b_push_align got=%b%b exp=01", held_t14, key_held); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow got=%b exp=0", overflow); end
    key_down[8] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (key_held === 1'b0) seen = 1'b1;
    end
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (evt.key_valid !== 1'b1 || evt.key_code !== KW'(exp_codes[k])) begin
        errors++; $display("FAIL b2b_drain_%0d got=%0d valid=%b exp=%0d", k, evt.key_code, evt.key_valid, exp_codes[k]);
      end
      evt.key_ready = 1'b1;
      tick();
      evt.key_ready = 1'b0;
    end
    checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", evt.key_valid); end
  endtask

  task automatic test_reset_mid_press();
    bit ok, seen;
    logic [KW-1:0] hc;
    int early;
    early = 0;
    evt.key_ready = 1'b0;
    do_press(5, ok, hc);
    checks++; if (!ok || evt.key_valid !== 1'b1) begin errors++; $display("FAIL rstm_pre_event got=%b exp=1", evt.key_valid); end
    key_down[0] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++; if (col_out !== 4'b0000) begin errors++; $display("FAIL rstm_col_out got=%b exp=0000", col_out); end
    checks++; if (evt.key_valid !== 1'b0 || evt.key_code !== 4'd0) begin errors++; $display("FAIL rstm_fifo got=%b/%0d exp=0/0", evt.key_valid, evt.key_code); end
    checks++; if (key_held !== 1'b0 || held_code !== 4'd0) begin errors++; $display("FAIL rstm_held got=%b/%0d exp=0/0", key_held, held_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstm_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (evt.key_valid !== 1'b0 || key_held !== 1'b0) early++;
    end
    tick();
    checks++; if (early != 0) begin errors++; $display("FAIL rstm_no_early_event got=%0d exp=0", early); end
    checks++; if (key_held !== 1'b1 || held_code !== 4'd0) begin errors++; $display("FAIL rstm_redebounce got=%b/%0d exp=1/0", key_held, held_code); end
    checks++; if (evt.key_valid !== 1'b1 || evt.key_code !== 4'd0) begin errors++; $display("FAIL rstm_new_event got=%b/%0d exp=1/0", evt.key_valid, evt.key_code); end
    key_down[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (key_held === 1'b0) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstm_release got=1 exp=0"); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    key_down = '0;
    row_force = '0;
    overflow_clr = 1'b0;
    evt.key_ready = 1'b0;
    test_reset();
    test_single_press();
    test_row_bounce();
    test_release_bounce();
    test_overflow();
    test_back_to_back();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
